// File: rtl/unidad_busqueda_if.sv
`default_nettype none
// ============================================================================
// Module  : unidad_busqueda_if
// Brief   : Instruction-memory req/ack port plus decoder valid/ready port.
// Rev     : 1.0  initial release
// ============================================================================
interface unidad_busqueda_if #(
    parameter int ANCHO_DIR   = 64,
    parameter int ANCHO_INSTR = 32
);
    logic                   mem_req;
    logic [ANCHO_DIR-1:0]   mem_dir;
    logic                   mem_ack;
    logic [ANCHO_INSTR-1:0] mem_dato;
    logic                   mem_err;

    logic [ANCHO_INSTR-1:0] instr;
    logic [ANCHO_DIR-1:0]   instr_dir;
    logic                   instr_valida;
    logic                   instr_listo;
    logic                   instr_falla;

    modport master (
        output mem_req, mem_dir,
        input  mem_ack, mem_dato, mem_err,
        output instr, instr_dir, instr_valida, instr_falla,
        input  instr_listo
    );

    modport slave (
        input  mem_req, mem_dir,
        output mem_ack, mem_dato, mem_err,
        input  instr, instr_dir, instr_valida, instr_falla,
        output instr_listo
    );
endinterface
`default_nettype wire

// File: rtl/unidad_busqueda.sv
`default_nettype none
// ============================================================================
// Module  : unidad_busqueda
// Brief   : Fetch stage: one instruction per PC value, faults and flush.
// Rev     : 1.0  initial release
// ============================================================================
module unidad_busqueda #(
    parameter int ANCHO_DIR   = 64,
    parameter int ANCHO_INSTR = 32,
    parameter int TIMEOUT     = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic [ANCHO_DIR-1:0] dirpc,
    input  wire logic                 redireccion,
    unidad_busqueda_if.master         bus,
    output logic                      pc_avanza
);
    localparam bit          c_timeout_en = (TIMEOUT != 0);
    localparam logic [16:0] c_timeout    = 17'(TIMEOUT);

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        PEDIR    = 2'd1,
        ENTREGAR = 2'd2
    } estado_t;

    estado_t                estado_q, estado_d;
    logic [ANCHO_DIR-1:0]   dir_q, dir_d;
    logic [ANCHO_INSTR-1:0] instr_q, instr_d;
    logic [ANCHO_DIR-1:0]   instr_dir_q, instr_dir_d;
    logic                   falla_q, falla_d;
    logic                   descartar_q, descartar_d;
    logic [15:0]            cnt_q, cnt_d;
    logic                   w_descarta;
    logic                   w_vence;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q    <= REPOSO;
            dir_q       <= '0;
            instr_q     <= '0;
            instr_dir_q <= '0;
            falla_q     <= 1'b0;
            descartar_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            estado_q    <= estado_d;
            dir_q       <= dir_d;
            instr_q     <= instr_d;
            instr_dir_q <= instr_dir_d;
            falla_q     <= falla_d;
            descartar_q <= descartar_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        estado_d    = estado_q;
        dir_d       = dir_q;
        instr_d     = instr_q;
        instr_dir_d = instr_dir_q;
        falla_d     = falla_q;
        descartar_d = descartar_q;
        cnt_d       = cnt_q;
        // A flush seen in this very cycle counts as well as one seen earlier.
        w_descarta  = descartar_q | redireccion;
        w_vence     = c_timeout_en && (({1'b0, cnt_q} + 17'd1) >= c_timeout);

        case (estado_q)
            REPOSO: begin
                if (!redireccion) begin
                    dir_d = dirpc;
                    if (dirpc[1:0] != 2'b00) begin
                        instr_d     = '0;
                        instr_dir_d = dirpc;
                        falla_d     = 1'b1;
                        estado_d    = ENTREGAR;
                    end else begin
                        cnt_d       = '0;
                        descartar_d = 1'b0;
                        estado_d    = PEDIR;
                    end
                end
            end
            PEDIR: begin
                if (bus.mem_ack || w_vence) begin
                    if (w_descarta) begin
                        descartar_d = 1'b0;
                        estado_d    = REPOSO;
                    end else begin
                        instr_d     = (bus.mem_ack && !bus.mem_err) ? bus.mem_dato : '0;
                        instr_dir_d = dir_q;
                        falla_d     = !bus.mem_ack || bus.mem_err;
                        estado_d    = ENTREGAR;
                    end
                end else begin
                    descartar_d = w_descarta;
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            ENTREGAR: begin
                if (redireccion || bus.instr_listo) begin
                    estado_d = REPOSO;
                end
            end
            default: estado_d = REPOSO;
        endcase
    end

    assign bus.mem_req      = (estado_q == PEDIR);
    assign bus.mem_dir      = dir_q;
    assign bus.instr        = instr_q;
    assign bus.instr_dir    = instr_dir_q;
    assign bus.instr_falla  = falla_q;
    assign bus.instr_valida = (estado_q == ENTREGAR);
    assign pc_avanza        = bus.instr_valida & bus.instr_listo & !redireccion;
endmodule
`default_nettype wire

// File: tb/tb_unidad_busqueda.sv
`default_nettype none
// Testbench for unidad_busqueda: per-transaction reference model, random traffic.
module tb_unidad_busqueda;
    localparam int TO = 16;

    logic        clk;
    logic        rst_n;
    logic [63:0] dirpc;
    logic        redireccion;
    logic        pc_avanza;
    int          checks;
    int          failures;

    unidad_busqueda_if #(.ANCHO_DIR(64), .ANCHO_INSTR(32)) bus ();

    unidad_busqueda #(.ANCHO_DIR(64), .ANCHO_INSTR(32), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dirpc      (dirpc),
        .redireccion(redireccion),
        .bus        (bus),
        .pc_avanza  (pc_avanza)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: a fetch is described by address, ack latency, error, data and
    // decoder stall; expected waveform follows from those alone.
    task automatic fetch_txn(input logic [63:0] a, input int lat, input logic e,
                             input logic [31:0] d, input int stall, input bit stray);
        bit          mis, timed;
        int          nreq, last;
        logic [31:0] ei;
        logic        ef;
        mis   = (a[1:0] != 2'b00);
        timed = !mis && (lat >= TO);
        nreq  = mis ? 0 : (timed ? TO : lat + 1);
        ei    = (mis || timed || e) ? 32'h0 : d;
        ef    = mis || timed || e;
        last  = 1 + nreq + stall;
        dirpc = a;
        redireccion = 1'b0;
        for (int c = 0; c <= last; c++) begin
            bit er, ev, real_ack;
            er       = (c >= 1) && (c <= nreq);
            ev       = (c >= 1 + nreq) && (c <= last);
            real_ack = !mis && !timed && (c == 1 + lat);
            bus.mem_ack     = real_ack || (stray && !er && c >= 1);
            bus.mem_dato    = real_ack ? d : $urandom;
            bus.mem_err     = real_ack ? e : 1'($urandom_range(0, 1));
            bus.instr_listo = (c == last);
            #1;
            checks++;
            if (bus.mem_req !== er) begin
                failures++;
                $display("FAIL txn_req a=%h c=%0d got=%b want=%b", a, c, bus.mem_req, er);
            end
            if (er) begin
                checks++;
                if (bus.mem_dir !== a) begin
                    failures++;
                    $display("FAIL txn_mem_dir c=%0d got=%h want=%h", c, bus.mem_dir, a);
                end
            end
            checks++;
            if (bus.instr_valida !== ev) begin
                failures++;
                $display("FAIL txn_valida a=%h c=%0d got=%b want=%b", a, c, bus.instr_valida, ev);
            end
            if (ev) begin
                checks++;
                if (bus.instr !== ei || bus.instr_dir !== a || bus.instr_falla !== ef) begin
                    failures++;
                    $display("FAIL txn_data c=%0d got=%h/%h/%b want=%h/%h/%b", c,
                             bus.instr, bus.instr_dir, bus.instr_falla, ei, a, ef);
                end
            end
            checks++;
            if (pc_avanza !== (c == last)) begin
                failures++;
                $display("FAIL txn_pc_avanza a=%h c=%0d got=%b want=%b", a, c, pc_avanza, c == last);
            end
            step();
        end
        bus.mem_ack = 1'b0;
        bus.instr_listo = 1'b0;
        #1;
        checks++;
        if (bus.instr_valida !== 1'b0 || bus.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL txn_idle got=%b/%b want=0/0", bus.instr_valida, bus.mem_req);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        redireccion = 1'b1;
        dirpc = 64'h0;
        bus.mem_ack = 1'b0;
        bus.mem_dato = 32'h0;
        bus.mem_err = 1'b0;
        bus.instr_listo = 1'b0;
        #23;
        checks++;
        if ({bus.mem_req, bus.instr_valida, bus.instr_falla, pc_avanza} !== 4'b0 ||
            bus.mem_dir !== 64'h0 || bus.instr !== 32'h0 || bus.instr_dir !== 64'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%b%b%b%b %h %h %h want=all zero", bus.mem_req,
                     bus.instr_valida, bus.instr_falla, pc_avanza, bus.mem_dir, bus.instr, bus.instr_dir);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_zero_wait();
        fetch_txn(64'h40, 0, 1'b0, 32'h8B020020, 0, 1'b0);
        fetch_txn(64'h44, 0, 1'b0, 32'h91000421, 0, 1'b0);
    endtask

    task automatic test_latency_backpressure();
        fetch_txn(64'h60, 5, 1'b0, $urandom, 3, 1'b0);
    endtask

    task automatic test_faults();
        fetch_txn(64'h42, 0, 1'b0, 32'hDEADBEEF, 1, 1'b0);
        fetch_txn(64'h48, 2, 1'b1, 32'hCAFEF00D, 0, 1'b0);
    endtask

    task automatic test_timeout();
        fetch_txn(64'h50, 1000, 1'b0, 32'h12345678, 2, 1'b1);
    endtask

    task automatic test_flush();
        // Flush while waiting for memory: req held to ack, nothing delivered.
        dirpc = 64'h80;
        redireccion = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            bit er;
            er = (c >= 1) && (c <= 4);
            redireccion = (c == 1);
            bus.mem_ack = (c == 4);
            bus.mem_dato = 32'hAAAA5555;
            bus.mem_err = 1'b0;
            bus.instr_listo = 1'b1;
            #1;
            checks++;
            if (bus.mem_req !== er || bus.instr_valida !== 1'b0 || pc_avanza !== 1'b0) begin
                failures++;
                $display("FAIL flush_pedir c=%0d got=%b%b%b want=%b00", c,
                         bus.mem_req, bus.instr_valida, pc_avanza, er);
            end
            if (c == 5) begin
                bus.mem_ack = 1'b0;
                bus.instr_listo = 1'b0;
            end else begin
                step();
            end
        end
        // Flush together with accept in ENTREGAR: no advance, refetch at 0x100.
        dirpc = 64'h84;
        bus.mem_ack = 1'b0;
        step();
        bus.mem_ack = 1'b1;
        bus.mem_dato = 32'h11112222;
        step();
        bus.mem_ack = 1'b0;
        redireccion = 1'b1;
        bus.instr_listo = 1'b1;
        dirpc = 64'h100;
        #1;
        checks++;
        if (bus.instr_valida !== 1'b1 || pc_avanza !== 1'b0) begin
            failures++;
            $display("FAIL flush_entregar got=%b%b want=10", bus.instr_valida, pc_avanza);
        end
        step();
        redireccion = 1'b0;
        bus.instr_listo = 1'b0;
        #1;
        checks++;
        if (bus.instr_valida !== 1'b0 || bus.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL flush_drop got=%b%b want=00", bus.instr_valida, bus.mem_req);
        end
        fetch_txn(64'h100, 1, 1'b0, 32'h0badcafe, 0, 1'b0);
    endtask

    task automatic test_reset_mid_fetch();
        dirpc = 64'h200;
        redireccion = 1'b0;
        step();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.instr_valida !== 1'b0 || pc_avanza !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got=%b%b%b want=000", bus.mem_req, bus.instr_valida, pc_avanza);
        end
        redireccion = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.instr_valida !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got=%b%b want=00", bus.mem_req, bus.instr_valida);
        end
        fetch_txn(64'h204, 0, 1'b0, 32'h55AA55AA, 1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic [63:0] a;
            a = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            fetch_txn(a, $urandom_range(0, 19), ($urandom_range(0, 7) == 0), $urandom,
                      $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_zero_wait();
        test_latency_backpressure();
        test_faults();
        test_timeout();
        test_flush();
        test_reset_mid_fetch();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/unidad_busqueda.md
Name: unidad_busqueda

Overview:
- Instruction-fetch stage directly downstream of the ProgramCounter; consumes its 64-bit dirout and returns one 32-bit instruction per PC value.
- Fetches through a req/ack instruction-memory port with variable latency; holds the result for the decoder under a valid/ready handshake.
- Pulses pc_avanza so the PC loads its next address only after the current instruction is consumed.
- Handles misalignment, memory error, memory timeout and branch-redirect flush.

Parameters:
ANCHO_DIR, 64, address width (PC and memory address)
ANCHO_INSTR, 32, instruction width
TIMEOUT, 16, max cycles waiting for mem_ack before fault; 0 disables timeout

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
dirpc  input  ANCHO_DIR  current PC (ProgramCounter dirout)
redireccion  input  1  flush: discard current fetch (branch taken upstream)
mem_req  output  1  memory read request
mem_dir  output  ANCHO_DIR  memory read address
mem_ack  input  1  memory response strobe, one cycle
mem_dato  input  ANCHO_INSTR  read data, valid with mem_ack
mem_err  input  1  bus error, valid with mem_ack
instr  output  ANCHO_INSTR  fetched instruction
instr_dir  output  ANCHO_DIR  address of instr
instr_valida  output  1  instr/instr_dir/instr_falla valid
instr_listo  input  1  decoder accepts
instr_falla  output  1  fetch fault (misaligned, mem_err, timeout); instr=0
pc_avanza  output  1  one-cycle pulse: PC may load next address

Behaviour:
- Reset (async, rst_n=0): state REPOSO; all outputs 0; timeout counter 0; descartar flag 0. Release is synchronous to next clk edge.
- States: REPOSO, PEDIR, ENTREGAR.
- REPOSO: if redireccion=1 stay. Otherwise latch dirpc into dir_reg.
  - dirpc[1:0]!=0 -> ENTREGAR with instr_falla=1, instr=0; no memory access.
  - Else -> PEDIR.
- PEDIR: mem_req=1, mem_dir=dir_reg, both stable until mem_ack. Counter increments each PEDIR cycle without ack.
  - mem_ack=1 -> register mem_dato into instr, dir_reg into instr_dir, mem_err into instr_falla (instr forced 0 on error) -> ENTREGAR. mem_req drops next cycle.
  - Ack in the same cycle req first rises is legal.
  - TIMEOUT!=0 and counter reaches TIMEOUT -> drop mem_req, instr_falla=1, instr=0 -> ENTREGAR. A late mem_ack arriving after this is ignored.
  - redireccion=1 in PEDIR: set descartar. mem_req stays high until mem_ack (the protocol forbids dropping req early). Ack data is discarded -> REPOSO. Timeout still applies, returning to REPOSO without delivering.
- ENTREGAR: instr_valida=1; instr, instr_dir and instr_falla held stable while instr_listo=0.
  - instr_listo=1 -> pc_avanza=1 that same cycle; next state REPOSO; instr_valida=0 next cycle.
  - redireccion=1 -> instr_valida drops next cycle, no pc_avanza, -> REPOSO. Wins over simultaneous instr_listo.
- pc_avanza is combinational (instr_valida & instr_listo & !redireccion), never high outside ENTREGAR.
- Minimum throughput, zero-wait memory: dirpc sampled cycle N, mem_req N+1 with ack N+1, instr_valida N+2, accept N+2, new dirpc sampled N+3. That is 3 cycles per instruction.
- Counter is 16-bit and saturates; cleared on entry to PEDIR.
- Reset mid-fetch: mem_req drops immediately (async). Any later mem_ack is ignored in REPOSO.

Test Plan:
- Zero-wait fetch: dirpc=0x40, mem_ack same cycle as req, mem_dato=0x8B020020, instr_listo=1 -> instr_valida one cycle with instr=0x8B020020, instr_dir=0x40, pc_avanza pulse; repeat dirpc=0x44 and check 3-cycle spacing.
- Latency + backpressure: ack 5 cycles after req, instr_listo low 3 cycles -> mem_req high exactly until ack; instr stable for 3 cycles; pc_avanza only on the accept cycle.
- Misalignment/error: dirpc=0x42 -> no mem_req, instr_valida with instr_falla=1, instr=0. Then dirpc=0x48 with mem_err=1 on ack -> instr_falla=1, instr_dir=0x48.
- Timeout: TIMEOUT=16, never ack -> mem_req high 16 cycles then low; instr_falla=1. A later stray mem_ack has no effect.
- Flush: redireccion during PEDIR -> req held to ack, no instr_valida, no pc_avanza. redireccion with instr_listo in ENTREGAR -> no pc_avanza; next fetch uses new dirpc=0x100.
- Reset mid-PEDIR: rst_n=0 asynchronously -> mem_req, instr_valida, pc_avanza all 0 before the next clk edge; fetch restarts cleanly after release.
